// File: rtl/pc_redirect_ctrl_if.sv
// Bundle between the pipeline (hazard/EX/CSR side) and the next-PC controller.
// master = pipeline side that drives requests, slave = pc_redirect_ctrl.
interface pc_redirect_ctrl_if #(
    parameter int XLEN = 32
) ();
    logic            hazard_stall;
    logic            br_redirect;
    logic [XLEN-1:0] br_pc;
    logic [XLEN-1:0] br_target;
    logic            trap_req;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_cause;
    logic            mret_req;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc_in;

    logic            pc_src;
    logic [XLEN-1:0] pc_target;
    logic            pc_stall;
    logic            flush_if;
    logic            flush_id;
    logic            flush_ex;
    logic            mepc_we;
    logic [XLEN-1:0] mepc_wdata;
    logic            mcause_we;
    logic [XLEN-1:0] mcause_wdata;
    logic            busy;

    modport master (
        output hazard_stall, br_redirect, br_pc, br_target, trap_req, trap_pc,
               trap_cause, mret_req, mtvec, mepc_in,
        input  pc_src, pc_target, pc_stall, flush_if, flush_id, flush_ex,
               mepc_we, mepc_wdata, mcause_we, mcause_wdata, busy
    );

    modport slave (
        input  hazard_stall, br_redirect, br_pc, br_target, trap_req, trap_pc,
               trap_cause, mret_req, mtvec, mepc_in,
        output pc_src, pc_target, pc_stall, flush_if, flush_id, flush_ex,
               mepc_we, mepc_wdata, mcause_we, mcause_wdata, busy
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Next-PC redirect arbiter: trap > mret > branch, with stalled-branch hold and trap entry sequencing.
// Optional macro PC_MISALIGN_TRAP_EN turns misaligned branch targets into an address-misaligned trap.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | normal flow; arbitrate trap / mret / branch / pending branch
// S_TRAP_SAVE | PC held, pipeline flushed, mepc/mcause written on first cycle
// S_TRAP_JUMP | one-cycle redirect to mtvec
// S_MRET_JUMP | one-cycle redirect to mepc
module pc_redirect_ctrl #(
    parameter int XLEN        = 32,
    parameter int TRAP_SETTLE = 1
) (
    input logic               clk,
    input logic               rst_n,
    pc_redirect_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_TRAP_SAVE,
        S_TRAP_JUMP,
        S_MRET_JUMP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(TRAP_SETTLE - 1);

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic            r_pend_valid;
    logic [XLEN-1:0] r_pend_target;
    logic [XLEN-1:0] r_save_pc;
    logic [XLEN-1:0] r_save_cause;

    logic            w_take_trap;
    logic [XLEN-1:0] w_trap_pc;
    logic [XLEN-1:0] w_trap_cause;
    logic [XLEN-1:0] w_br_tgt;
    logic            w_first_save;

    logic            w_pc_src;
    logic [XLEN-1:0] w_pc_target;
    logic            w_pc_stall;
    logic            w_flush_if;
    logic            w_flush_id;
    logic            w_flush_ex;

`ifdef PC_MISALIGN_TRAP_EN
    logic w_misalign;
    logic w_unused;

    // A misaligned taken branch becomes cause 0, but a real trap keeps its own cause.
    assign w_misalign   = bus.br_redirect && (bus.br_target[1:0] != 2'b00);
    assign w_take_trap  = bus.trap_req || w_misalign;
    assign w_trap_pc    = bus.trap_req ? bus.trap_pc : bus.br_pc;
    assign w_trap_cause = bus.trap_req ? bus.trap_cause : '0;
    assign w_br_tgt     = bus.br_target;
    assign w_unused     = ^{bus.mtvec[1:0], bus.mepc_in[1:0]};
`else
    logic w_unused;

    assign w_take_trap  = bus.trap_req;
    assign w_trap_pc    = bus.trap_pc;
    assign w_trap_cause = bus.trap_cause;
    assign w_br_tgt     = {bus.br_target[XLEN-1:2], 2'b00};
    assign w_unused     = ^{bus.mtvec[1:0], bus.mepc_in[1:0], bus.br_target[1:0], bus.br_pc};
`endif

    assign w_first_save = (r_state == S_TRAP_SAVE) && (r_cnt == CNT_INIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
            r_save_pc     <= '0;
            r_save_cause  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_take_trap) begin
                        r_save_pc    <= {w_trap_pc[XLEN-1:2], 2'b00};
                        r_save_cause <= w_trap_cause;
                        r_cnt        <= CNT_INIT;
                        r_pend_valid <= 1'b0;
                        r_state      <= S_TRAP_SAVE;
                    end else if (bus.mret_req) begin
                        r_pend_valid <= 1'b0;
                        r_state      <= S_MRET_JUMP;
                    end else if (bus.br_redirect) begin
                        // Newest branch wins; an unstalled branch supersedes anything held.
                        r_pend_valid  <= bus.hazard_stall;
                        r_pend_target <= w_br_tgt;
                    end else if (r_pend_valid && !bus.hazard_stall) begin
                        r_pend_valid <= 1'b0;
                    end
                end
                S_TRAP_SAVE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_TRAP_JUMP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_TRAP_JUMP: r_state <= S_IDLE;
                S_MRET_JUMP: r_state <= S_IDLE;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pc_src    = 1'b0;
        w_pc_target = '0;
        w_pc_stall  = 1'b0;
        w_flush_if  = 1'b0;
        w_flush_id  = 1'b0;
        w_flush_ex  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_take_trap || bus.mret_req) begin
                    w_pc_stall = 1'b1;
                    w_flush_if = 1'b1;
                    w_flush_id = 1'b1;
                end else if (bus.br_redirect && !bus.hazard_stall) begin
                    w_pc_src    = 1'b1;
                    w_pc_target = w_br_tgt;
                    w_flush_if  = 1'b1;
                    w_flush_id  = 1'b1;
                end else if (bus.br_redirect) begin
                    // Branch already left EX; only the wrong-path instruction in ID dies.
                    w_pc_stall = 1'b1;
                    w_flush_id = 1'b1;
                end else if (r_pend_valid && !bus.hazard_stall) begin
                    w_pc_src    = 1'b1;
                    w_pc_target = r_pend_target;
                    w_flush_if  = 1'b1;
                end else begin
                    w_pc_stall = bus.hazard_stall;
                end
            end
            S_TRAP_SAVE: begin
                w_pc_stall = 1'b1;
                w_flush_if = 1'b1;
                w_flush_id = 1'b1;
                w_flush_ex = 1'b1;
            end
            S_TRAP_JUMP: begin
                w_pc_src    = 1'b1;
                w_pc_target = {bus.mtvec[XLEN-1:2], 2'b00};
                w_flush_if  = 1'b1;
                w_flush_id  = 1'b1;
            end
            S_MRET_JUMP: begin
                w_pc_src    = 1'b1;
                w_pc_target = {bus.mepc_in[XLEN-1:2], 2'b00};
                w_flush_if  = 1'b1;
                w_flush_id  = 1'b1;
            end
            default: begin
                w_pc_stall = 1'b0;
            end
        endcase
    end

    assign bus.pc_src       = w_pc_src;
    assign bus.pc_target    = w_pc_target;
    assign bus.pc_stall     = w_pc_stall;
    assign bus.flush_if     = w_flush_if;
    assign bus.flush_id     = w_flush_id;
    assign bus.flush_ex     = w_flush_ex;
    assign bus.mepc_we      = w_first_save;
    assign bus.mepc_wdata   = w_first_save ? r_save_pc : '0;
    assign bus.mcause_we    = w_first_save;
    assign bus.mcause_wdata = w_first_save ? r_save_cause : '0;
    assign bus.busy         = (r_state != S_IDLE);
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl with TRAP_SETTLE=2; expected output vectors are queued per cycle.
module tb_pc_redirect_ctrl;
    localparam int XLEN = 32;

    logic clk;
    logic rst_n;

    pc_redirect_ctrl_if #(.XLEN(XLEN)) bus ();

    pc_redirect_ctrl #(.XLEN(XLEN), .TRAP_SETTLE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        src;
        logic [31:0] tgt;
        logic        stall;
        logic        fif;
        logic        fid;
        logic        fex;
        logic        mwe;
        logic [31:0] mwd;
        logic        cwe;
        logic [31:0] cwd;
        logic        busy;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic src, input logic [31:0] tgt, input logic stall,
                                input logic fif, input logic fid, input logic fex,
                                input logic mwe, input logic [31:0] mwd,
                                input logic cwe, input logic [31:0] cwd, input logic busy);
        exp_t e;
        e.src = src; e.tgt = tgt; e.stall = stall; e.fif = fif; e.fid = fid; e.fex = fex;
        e.mwe = mwe; e.mwd = mwd; e.cwe = cwe; e.cwd = cwd; e.busy = busy;
        return e;
    endfunction

    // Drive one cycle of stimulus after the falling edge, check outputs mid-low-phase.
    task automatic cyc(input string name, input logic hs, input logic br,
                       input logic [31:0] bpc, input logic [31:0] bt,
                       input logic tr, input logic [31:0] tpc, input logic [31:0] tc,
                       input logic mr, input exp_t e);
        exp_t g;
        bus.hazard_stall = hs;
        bus.br_redirect  = br;
        bus.br_pc        = bpc;
        bus.br_target    = bt;
        bus.trap_req     = tr;
        bus.trap_pc      = tpc;
        bus.trap_cause   = tc;
        bus.mret_req     = mr;
        q.push_back(e);
        #2;
        g = q.pop_front();
        check({name, ".pc_src"},       32'(bus.pc_src),    32'(g.src));
        check({name, ".pc_target"},    bus.pc_target,      g.tgt);
        check({name, ".pc_stall"},     32'(bus.pc_stall),  32'(g.stall));
        check({name, ".flush_if"},     32'(bus.flush_if),  32'(g.fif));
        check({name, ".flush_id"},     32'(bus.flush_id),  32'(g.fid));
        check({name, ".flush_ex"},     32'(bus.flush_ex),  32'(g.fex));
        check({name, ".mepc_we"},      32'(bus.mepc_we),   32'(g.mwe));
        check({name, ".mepc_wdata"},   bus.mepc_wdata,     g.mwd);
        check({name, ".mcause_we"},    32'(bus.mcause_we), 32'(g.cwe));
        check({name, ".mcause_wdata"}, bus.mcause_wdata,   g.cwd);
        check({name, ".busy"},         32'(bus.busy),      32'(g.busy));
        @(negedge clk);
    endtask

    exp_t E0, E_STALL, E_ENTRY, E_SAVE, E_JMP_VEC;

    initial begin
        E0        = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_STALL   = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        E_ENTRY   = mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        E_SAVE    = mk(0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1);
        E_JMP_VEC = mk(1, 32'h800, 0, 1, 1, 0, 0, 0, 0, 0, 1);

        rst_n       = 1'b0;
        bus.mtvec   = 32'h801;
        bus.mepc_in = 32'h1234;

        // Reset: everything zero, pc_stall follows hazard_stall
        cyc("rst",    0, 0, 0, 0, 0, 0, 0, 0, E0);
        cyc("rst_hs", 1, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        cyc("idle",   0, 0, 0, 0, 0, 0, 0, 0, E0);

        // Branch without stall: zero-latency redirect
        cyc("br",      0, 1, 32'h10, 32'h100, 0, 0, 0, 0, mk(1, 32'h100, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        cyc("br_post", 0, 0, 0, 0, 0, 0, 0, 0, E0);

        // Branch during a 3-cycle stall is held until release
        cyc("brs0",     1, 1, 32'h20, 32'h200, 0, 0, 0, 0, E_STALL);
        cyc("brs1",     1, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("brs2",     1, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("brs_rel",  0, 0, 0, 0, 0, 0, 0, 0, mk(1, 32'h200, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        cyc("brs_post", 0, 0, 0, 0, 0, 0, 0, 0, E0);

        // Newest stalled branch overwrites the pending target
        cyc("ovr0",    1, 1, 0, 32'h300, 0, 0, 0, 0, E_STALL);
        cyc("ovr1",    1, 1, 0, 32'h340, 0, 0, 0, 0, E_STALL);
        cyc("ovr_rel", 0, 0, 0, 0, 0, 0, 0, 0, mk(1, 32'h340, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        cyc("ovr_post",0, 0, 0, 0, 0, 0, 0, 0, E0);

        // Trap, TRAP_SETTLE=2; hazard_stall high during the sequence is ignored
        cyc("trap_in",  0, 0, 0, 0, 1, 32'h44, 32'h2, 0, E_ENTRY);
        cyc("trap_s1",  1, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 1, 1, 1, 1, 1, 32'h44, 1, 32'h2, 1));
        cyc("trap_s2",  1, 0, 0, 0, 0, 0, 0, 0, E_SAVE);
        cyc("trap_jmp", 1, 0, 0, 0, 0, 0, 0, 0, E_JMP_VEC);
        cyc("trap_end", 0, 0, 0, 0, 0, 0, 0, 0, E0);

        // Simultaneous requests with a pending branch: trap only, pending discarded
        cyc("sim_pend", 1, 1, 0, 32'h300, 0, 0, 0, 0, E_STALL);
        cyc("sim_in",   0, 1, 0, 32'h400, 1, 32'h8b, 32'h5, 1, E_ENTRY);
        cyc("sim_s1",   0, 1, 0, 32'h500, 0, 0, 0, 1, mk(0, 0, 1, 1, 1, 1, 1, 32'h88, 1, 32'h5, 1));
        cyc("sim_s2",   0, 1, 0, 32'h500, 1, 32'h99, 32'h7, 0, E_SAVE);
        cyc("sim_jmp",  0, 1, 0, 32'h500, 0, 0, 0, 0, E_JMP_VEC);
        cyc("sim_end",  0, 0, 0, 0, 0, 0, 0, 0, E0);

        // mret
        cyc("mret_in",  0, 0, 0, 0, 0, 0, 0, 1, E_ENTRY);
        cyc("mret_jmp", 1, 0, 0, 0, 0, 0, 0, 0, mk(1, 32'h1234, 0, 1, 1, 0, 0, 0, 0, 0, 1));
        cyc("mret_end", 0, 0, 0, 0, 0, 0, 0, 0, E0);

        // Reset asserted while in TRAP_SAVE: immediate return to idle, no CSR write afterwards
        cyc("rtrap_in", 0, 0, 0, 0, 1, 32'h60, 32'h3, 0, E_ENTRY);
        rst_n = 1'b0;
        cyc("rtrap_rst0", 0, 0, 0, 0, 0, 0, 0, 0, E0);
        cyc("rtrap_rst1", 0, 0, 0, 0, 0, 0, 0, 0, E0);
        rst_n = 1'b1;
        cyc("rtrap_idle0", 0, 0, 0, 0, 0, 0, 0, 0, E0);
        cyc("rtrap_idle1", 0, 0, 0, 0, 0, 0, 0, 0, E0);
        cyc("rtrap_br",    0, 1, 0, 32'h180, 0, 0, 0, 0, mk(1, 32'h180, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        cyc("rtrap_post",  0, 0, 0, 0, 0, 0, 0, 0, E0);

        // Misaligned branch target
`ifdef PC_MISALIGN_TRAP_EN
        cyc("mis_in",  0, 1, 32'h50, 32'h102, 0, 0, 0, 0, E_ENTRY);
        cyc("mis_s1",  0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 1, 1, 1, 1, 1, 32'h50, 1, 32'h0, 1));
        cyc("mis_s2",  0, 0, 0, 0, 0, 0, 0, 0, E_SAVE);
        cyc("mis_jmp", 0, 0, 0, 0, 0, 0, 0, 0, E_JMP_VEC);
        cyc("mis_end", 0, 0, 0, 0, 0, 0, 0, 0, E0);
        cyc("mis_tr",  0, 1, 32'h50, 32'h102, 1, 32'h70, 32'h9, 0, E_ENTRY);
        cyc("mis_tr1", 0, 0, 0, 0, 0, 0, 0, 0, mk(0, 0, 1, 1, 1, 1, 1, 32'h70, 1, 32'h9, 1));
        cyc("mis_tr2", 0, 0, 0, 0, 0, 0, 0, 0, E_SAVE);
        cyc("mis_tr3", 0, 0, 0, 0, 0, 0, 0, 0, E_JMP_VEC);
        cyc("mis_tr4", 0, 0, 0, 0, 0, 0, 0, 0, E0);
`else
        cyc("mis_br",   0, 1, 32'h50, 32'h102, 0, 0, 0, 0, mk(1, 32'h100, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        cyc("mis_post", 0, 0, 0, 0, 0, 0, 0, 0, E0);
        cyc("mis_st",   1, 1, 32'h50, 32'h203, 0, 0, 0, 0, E_STALL);
        cyc("mis_rel",  0, 0, 0, 0, 0, 0, 0, 0, mk(1, 32'h200, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        cyc("mis_end",  0, 0, 0, 0, 0, 0, 0, 0, E0);
`endif

        check("sb_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
